// File: rtl/sp_ram_pkg.sv
// Shared constants for the single-port RAM arbiter: FSM encoding and requester count.
package sp_ram_pkg;

   // FSM encoding kept as plain constants so older code can compare against them directly
   localparam logic [0:0] ST_INIT  = 1'b0;   // zero sweep in progress
   localparam logic [0:0] ST_SERVE = 1'b1;   // arbitrating requesters

   localparam int NUM_REQ = 2;

endpackage

// File: rtl/sp_ram_rr_pick.sv
// Two-way round-robin pick: a lone requester always wins; on a tie the
// requester that was not granted most recently wins.
module sp_ram_rr_pick
   import sp_ram_pkg::*;
(
   input  logic [NUM_REQ-1:0] valid,
   input  logic               last,    // index of the most recent grant
   output logic [NUM_REQ-1:0] grant
);

   // one-hot grant, or zero when nobody asks
   always_comb begin
      grant = '0;
      if (valid == 2'b11)
         grant = last ? 2'b01 : 2'b10;
      else
         grant = valid;
   end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Arbitrates two requesters onto one external single-port RAM. After reset
// (or a flush) the whole RAM is written to zero before any request is served.
module sp_ram_arbiter
   import sp_ram_pkg::*;
#(
   parameter int RAM_ADDR_WIDTH = 10,
   parameter int RAM_DATA_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      req0_valid,
   output logic                      req0_ready,
   input  logic                      req0_wen,
   input  logic [RAM_ADDR_WIDTH-1:0] req0_addr,
   input  logic [RAM_DATA_WIDTH-1:0] req0_wdata,
   input  logic                      req1_valid,
   output logic                      req1_ready,
   input  logic                      req1_wen,
   input  logic [RAM_ADDR_WIDTH-1:0] req1_addr,
   input  logic [RAM_DATA_WIDTH-1:0] req1_wdata,
   output logic                      resp0_valid,
   output logic [RAM_DATA_WIDTH-1:0] resp0_rdata,
   output logic                      resp1_valid,
   output logic [RAM_DATA_WIDTH-1:0] resp1_rdata,
   output logic                      ram_en,
   output logic                      ram_wen,
   output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
   output logic [RAM_DATA_WIDTH-1:0] ram_din,
   input  logic [RAM_DATA_WIDTH-1:0] ram_dout,
   output logic                      init_done
);

   logic [0:0]                state;
   logic [RAM_ADDR_WIDTH-1:0] cnt;       // sweep address
   logic                      last;      // index of the most recent grant
   logic [NUM_REQ-1:0]        rd_pend;   // read accepted last cycle, per requester
   logic [NUM_REQ-1:0]        valid;
   logic [NUM_REQ-1:0]        pick;
   logic [NUM_REQ-1:0]        grant;
   logic                      serve;

   assign serve = (state == ST_SERVE);
   assign valid = {req1_valid, req0_valid};

   sp_ram_rr_pick u_pick (
      .valid (valid),
      .last  (last),
      .grant (pick)
   );

   // flush wins over any request in the same cycle; nothing is granted during the sweep
   assign grant      = (serve && !flush) ? pick : '0;
   assign req0_ready = grant[0];
   assign req1_ready = grant[1];
   assign init_done  = serve;

   // RAM port mux: sweep writes zeros, otherwise forward the granted requester or stay idle
   always_comb begin
      ram_en   = 1'b0;
      ram_wen  = 1'b0;
      ram_addr = '0;
      ram_din  = '0;
      if (!serve) begin
         ram_en   = 1'b1;
         ram_wen  = 1'b1;
         ram_addr = cnt;
      end else if (grant[0]) begin
         ram_en   = 1'b1;
         ram_wen  = req0_wen;
         ram_addr = req0_addr;
         ram_din  = req0_wdata;
      end else if (grant[1]) begin
         ram_en   = 1'b1;
         ram_wen  = req1_wen;
         ram_addr = req1_addr;
         ram_din  = req1_wdata;
      end
   end

   // RAM output is registered, so read data belongs to whoever was granted a read last cycle
   assign resp0_valid = rd_pend[0];
   assign resp1_valid = rd_pend[1];
   assign resp0_rdata = rd_pend[0] ? ram_dout : '0;
   assign resp1_rdata = rd_pend[1] ? ram_dout : '0;

   // FSM, sweep counter, round-robin history and pending-read flags
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_INIT;
         cnt     <= '0;
         last    <= 1'b1;
         rd_pend <= '0;
      end else begin
         // a read issued just before a flush still gets its response
         rd_pend <= grant & ~{req1_wen, req0_wen};
         if (!serve) begin
            cnt <= cnt + 1'b1;
            if (&cnt) begin
               state <= ST_SERVE;
               cnt   <= '0;
            end
         end else if (flush) begin
            state <= ST_INIT;
            cnt   <= '0;
         end else if (|grant) begin
            last <= grant[1];
         end
      end
   end

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Self-checking bench for sp_ram_arbiter with a 16-word behavioural RAM and
// a transaction-level reference model (shadow memory, round-robin history).
module tb_sp_ram_arbiter;

   localparam int AW = 4;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          reset, flush;
   logic          req0_valid, req0_ready, req0_wen;
   logic [AW-1:0] req0_addr;
   logic [DW-1:0] req0_wdata;
   logic          req1_valid, req1_ready, req1_wen;
   logic [AW-1:0] req1_addr;
   logic [DW-1:0] req1_wdata;
   logic          resp0_valid, resp1_valid;
   logic [DW-1:0] resp0_rdata, resp1_rdata;
   logic          ram_en, ram_wen;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout = '0;
   logic          init_done;

   int nchk = 0;
   int nfail = 0;

   always #5 clk = ~clk;

   sp_ram_arbiter #(.RAM_ADDR_WIDTH(AW), .RAM_DATA_WIDTH(DW)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_wen(req0_wen),
      .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_wen(req1_wen),
      .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata),
      .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata),
      .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_din(ram_din),
      .ram_dout(ram_dout), .init_done(init_done)
   );

   // external RAM: registered output, read-first
   logic [DW-1:0] ram_mem [16];
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_wen) ram_mem[ram_addr] <= ram_din;
         ram_dout <= ram_mem[ram_addr];
      end
   end

   // reference model state
   bit            m_init;
   int            m_cnt;
   bit            m_last;
   logic [DW-1:0] m_mem [16];
   bit   [1:0]    e_pend;
   logic [DW-1:0] e_data [2];
   logic [1:0]    obs_g;
   logic          obs_en;

   task automatic apply_reset();
      reset = 1'b1; flush = 1'b0;
      req0_valid = 0; req0_wen = 0; req0_addr = '0; req0_wdata = '0;
      req1_valid = 0; req1_wen = 0; req1_addr = '0; req1_wdata = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      m_init = 1; m_cnt = 0; m_last = 1; e_pend = '0;
   endtask

   // one clock: drive, compare against the model mid-cycle, advance the model
   task automatic do_cycle(input bit rst, input bit fl,
                           input bit v0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                           input bit v1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
      logic [1:0] eg;
      logic       xen, xwen;
      logic [AW-1:0] xaddr;
      logic [DW-1:0] xdin;
      reset = rst; flush = fl;
      req0_valid = v0; req0_wen = w0; req0_addr = a0; req0_wdata = d0;
      req1_valid = v1; req1_wen = w1; req1_addr = a1; req1_wdata = d1;
      @(negedge clk);
      nchk++;
      if (resp0_valid !== e_pend[0] || resp0_rdata !== (e_pend[0] ? e_data[0] : 16'h0)) begin
         nfail++;
         $display("FAIL resp0: got v=%0b d=%0h want v=%0b d=%0h", resp0_valid, resp0_rdata,
                  e_pend[0], e_pend[0] ? e_data[0] : 16'h0);
      end
      nchk++;
      if (resp1_valid !== e_pend[1] || resp1_rdata !== (e_pend[1] ? e_data[1] : 16'h0)) begin
         nfail++;
         $display("FAIL resp1: got v=%0b d=%0h want v=%0b d=%0h", resp1_valid, resp1_rdata,
                  e_pend[1], e_pend[1] ? e_data[1] : 16'h0);
      end
      eg = 2'b00;
      if (m_init) begin
         xen = 1; xwen = 1; xaddr = AW'(m_cnt); xdin = '0;
      end else begin
         if (!fl) begin
            if (v0 && v1) eg = m_last ? 2'b01 : 2'b10;
            else          eg = {v1, v0};
         end
         if (eg[0])      begin xen = 1; xwen = w0; xaddr = a0; xdin = d0; end
         else if (eg[1]) begin xen = 1; xwen = w1; xaddr = a1; xdin = d1; end
         else            begin xen = 0; xwen = 0;  xaddr = '0; xdin = '0; end
      end
      nchk++;
      if ({req1_ready, req0_ready} !== eg || init_done !== !m_init) begin
         nfail++;
         $display("FAIL grant: got rdy=%b done=%b want rdy=%b done=%b",
                  {req1_ready, req0_ready}, init_done, eg, !m_init);
      end
      nchk++;
      if (ram_en !== xen || ram_wen !== xwen || ram_addr !== xaddr || ram_din !== xdin) begin
         nfail++;
         $display("FAIL ram_port: got en=%b wen=%b a=%0h d=%0h want en=%b wen=%b a=%0h d=%0h",
                  ram_en, ram_wen, ram_addr, ram_din, xen, xwen, xaddr, xdin);
      end
      obs_g = {req1_ready, req0_ready};
      obs_en = ram_en;
      @(posedge clk);
      #1;
      // memory effects happen even in a reset cycle, since the RAM is outside the block
      e_pend[0] = eg[0] && !w0;
      e_pend[1] = eg[1] && !w1;
      e_data[0] = m_mem[a0];
      e_data[1] = m_mem[a1];
      if (eg[0] && w0) m_mem[a0] = d0;
      if (eg[1] && w1) m_mem[a1] = d1;
      if (m_init) begin
         m_mem[m_cnt] = '0;
         if (m_cnt == 15) begin m_init = 0; m_cnt = 0; end
         else m_cnt++;
      end else if (fl) begin
         m_init = 1; m_cnt = 0;
      end else if (eg != 0) begin
         m_last = eg[1];
      end
      if (rst) begin
         m_init = 1; m_cnt = 0; m_last = 1; e_pend = '0;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      apply_reset();
      nchk++;
      if (init_done !== 1'b0 || ram_addr !== 4'h0 || resp0_valid !== 1'b0 || resp1_valid !== 1'b0) begin
         nfail++;
         $display("FAIL reset_state: done=%b addr=%0h rv0=%b rv1=%b want 0 0 0 0",
                  init_done, ram_addr, resp0_valid, resp1_valid);
      end
      // requests and flush during the sweep must be ignored
      for (int i = 0; i < 16; i++)
         do_cycle(0, (i == 5), 1, 0, 4'(i), 16'h5555, (i % 2 == 0), 1, 4'(i), 16'hAAAA);
      nchk++;
      if (init_done !== 1'b1) begin
         nfail++;
         $display("FAIL sweep_len: init_done=%b want 1", init_done);
      end
      do_cycle(0, 0, 1, 0, 4'd7, 16'h0, 0, 0, 0, 0);
      nchk++;
      if (resp0_valid !== 1'b1 || resp0_rdata !== 16'h0000) begin
         nfail++;
         $display("FAIL read_zero: v=%b d=%0h want v=1 d=0", resp0_valid, resp0_rdata);
      end
      idle(1);
   endtask

   task automatic test_write_read();
      do_cycle(0, 0, 1, 1, 4'd3, 16'hBEEF, 0, 0, 0, 0);
      nchk++;
      if (resp0_valid !== 1'b0) begin
         nfail++;
         $display("FAIL write_no_resp: v=%b want 0", resp0_valid);
      end
      do_cycle(0, 0, 1, 0, 4'd3, 16'h0, 0, 0, 0, 0);
      nchk++;
      if (resp0_valid !== 1'b1 || resp0_rdata !== 16'hBEEF || resp1_valid !== 1'b0) begin
         nfail++;
         $display("FAIL write_read: v0=%b d0=%0h v1=%b want 1 beef 0", resp0_valid, resp0_rdata, resp1_valid);
      end
      idle(1);
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_g [4];
      exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
      apply_reset();
      idle(16);
      for (int i = 0; i < 4; i++) begin
         do_cycle(0, 0, 1, 0, 4'(i), 16'h0, 1, 0, 4'(i + 8), 16'h0);
         nchk++;
         if (obs_g !== exp_g[i] || obs_en !== 1'b1) begin
            nfail++;
            $display("FAIL rr_%0d: grant=%b en=%b want grant=%b en=1", i, obs_g, obs_en, exp_g[i]);
         end
      end
      idle(1);
   endtask

   task automatic test_flush();
      do_cycle(0, 0, 1, 1, 4'd3, 16'h1234, 0, 0, 0, 0);
      do_cycle(0, 1, 0, 0, 0, 0, 1, 0, 4'd3, 16'h0);
      nchk++;
      if (obs_g[1] !== 1'b0) begin
         nfail++;
         $display("FAIL flush_prio: req1_ready=%b want 0", obs_g[1]);
      end
      idle(16);
      do_cycle(0, 0, 1, 0, 4'd3, 16'h0, 0, 0, 0, 0);
      nchk++;
      if (resp0_valid !== 1'b1 || resp0_rdata !== 16'h0000) begin
         nfail++;
         $display("FAIL flush_zero: v=%b d=%0h want 1 0", resp0_valid, resp0_rdata);
      end
      idle(1);
   endtask

   task automatic test_reset_mid_sweep();
      do_cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(9);
      do_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      nchk++;
      if (ram_addr !== 4'h0 || init_done !== 1'b0) begin
         nfail++;
         $display("FAIL reset_mid: addr=%0h done=%b want 0 0", ram_addr, init_done);
      end
      idle(15);
      nchk++;
      if (init_done !== 1'b0) begin
         nfail++;
         $display("FAIL restart_len15: done=%b want 0", init_done);
      end
      idle(1);
      nchk++;
      if (init_done !== 1'b1) begin
         nfail++;
         $display("FAIL restart_len16: done=%b want 1", init_done);
      end
   endtask

   task automatic test_flush_pending();
      do_cycle(0, 0, 1, 1, 4'd5, 16'hC0DE, 0, 0, 0, 0);
      do_cycle(0, 0, 1, 0, 4'd5, 16'h0, 0, 0, 0, 0);
      do_cycle(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      nchk++;
      if (resp0_valid !== 1'b0) begin
         nfail++;
         $display("FAIL flush_pend_once: v=%b want 0", resp0_valid);
      end
      idle(16);
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++)
         do_cycle(0, ($urandom_range(49) == 0),
                  1'($urandom), 1'($urandom), 4'($urandom), 16'($urandom),
                  1'($urandom), 1'($urandom), 4'($urandom), 16'($urandom));
   endtask

   initial begin
      for (int i = 0; i < 16; i++) m_mem[i] = '0;
      e_data[0] = '0; e_data[1] = '0;
      test_reset();
      test_write_read();
      test_round_robin();
      test_flush();
      test_reset_mid_sweep();
      test_flush_pending();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
